des_key_schedule: RTL

- Iterative DES key schedule that produces the 48-bit round subkey XORed with the E-expanded half-block ahead of the eight S-box lookups.
- Upstream neighbour of the S-box stage in the round datapath.
- Loads one 64-bit key, applies PC-1, then emits K1..K16 (encrypt) or K16..K1 (decrypt), one per accepted valid/ready handshake.
- Bit numbering follows FIPS 46-3: bit 1 = MSB.

---
 rtl/des_key_schedule.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on load, per-round C/D rotation, PC-2 subkey output.
// Optional key byte parity check is enabled by defining DES_KS_PARITY_CHK_EN.
module des_key_schedule #(
    parameter int OUT_REG = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:64] key_in,
    input  logic        decrypt,
    output logic        busy,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [1:48] subkey,
    output logic [3:0]  round,
    output logic        last,
    output logic        key_err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int PC1 [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] o;
        for (int i = 1; i <= 56; i++) o[i] = k[PC1[i]];
        return o;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] o;
        for (int i = 1; i <= 48; i++) o[i] = cd[PC2[i]];
        return o;
    endfunction

    function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
        return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
        return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

    // Shift table entries 1, 2, 9 and 16 rotate by one; all others by two.
    function automatic logic isTwo(input logic [4:0] idx);
        return !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);
    endfunction

    state_t      r_state, w_state_next;
    logic        r_dir, w_dir_next;
    logic [1:28] r_c, r_d, w_c_next, w_d_next;
    logic [3:0]  r_round, w_round_next;
    logic [1:56] w_cd0;
    logic        w_parity_ok;
    logic        w_start_ok;
    logic        w_hs;
    logic [4:0]  w_enc_idx, w_dec_idx;

`ifdef DES_KS_PARITY_CHK_EN
    function automatic logic parityOk(input logic [1:64] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) ok = ok & (^k[8*b+1 +: 8]);
        return ok;
    endfunction

    logic r_key_err;
    assign w_parity_ok = parityOk(key_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_key_err <= 1'b0;
        else        r_key_err <= (r_state == IDLE) && start && !w_parity_ok;
    end
    assign key_err = r_key_err;
`else
    logic w_unused_parity;
    assign w_unused_parity = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                               key_in[40], key_in[48], key_in[56], key_in[64]};
    assign w_parity_ok = 1'b1;
    assign key_err     = 1'b0;
`endif

    assign w_cd0      = pc1(key_in);
    assign w_start_ok = (r_state == IDLE) && start && w_parity_ok;
    assign w_hs       = (r_state == RUN) && sk_ready;
    assign w_enc_idx  = {1'b0, r_round} + 5'd2;
    assign w_dec_idx  = 5'd16 - {1'b0, r_round};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dir   <= 1'b0;
            r_c     <= '0;
            r_d     <= '0;
            r_round <= '0;
        end else begin
            r_state <= w_state_next;
            r_dir   <= w_dir_next;
            r_c     <= w_c_next;
            r_d     <= w_d_next;
            r_round <= w_round_next;
        end
    end

    // Decrypt loads C0/D0 as-is because that pair is identical to C16/D16.
    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_c_next     = r_c;
        w_d_next     = r_d;
        w_round_next = r_round;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_next = RUN;
                    w_dir_next   = decrypt;
                    w_round_next = 4'd0;
                    if (decrypt) begin
                        w_c_next = w_cd0[1:28];
                        w_d_next = w_cd0[29:56];
                    end else begin
                        w_c_next = rotl(w_cd0[1:28], 1'b0);
                        w_d_next = rotl(w_cd0[29:56], 1'b0);
                    end
                end
            end
            RUN: begin
                if (w_hs) begin
                    if (r_round == 4'd15) begin
                        w_state_next = IDLE;
                        w_round_next = 4'd0;
                    end else begin
                        w_round_next = r_round + 4'd1;
                        if (r_dir) begin
                            w_c_next = rotr(r_c, isTwo(w_dec_idx));
                            w_d_next = rotr(r_d, isTwo(w_dec_idx));
                        end else begin
                            w_c_next = rotl(r_c, isTwo(w_enc_idx));
                            w_d_next = rotl(r_d, isTwo(w_enc_idx));
                        end
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The registered variant computes PC-2 from next-state C/D so timing matches the combinational one.
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [1:48] r_subkey;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_subkey <= '0;
                else        r_subkey <= pc2({w_c_next, w_d_next});
            end
            assign subkey = r_subkey;
        end else begin : g_out_comb
            assign subkey = pc2({r_c, r_d});
        end
    endgenerate

    assign busy     = (r_state == RUN);
    assign sk_valid = busy;
    assign round    = r_round;
    assign last     = busy && (r_round == 4'd15);

endmodule
